// File: rtl/grf_writeback.sv
// grf_writeback: W stage of the five-stage MIPS pipeline plus the 32x32
// general register file. Decodes the W instruction, selects and extends the
// writeback value, commits it on the clock edge, serves the two D-stage
// read ports and counts retired (non-bubble) instructions.
// Optional feature macro: GRF_BYPASS_EN (write-before-read on the read ports).
module grf_writeback #(
  parameter logic [31:0] PC_RESET = 32'h00003000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] W_PC,
  input  logic [31:0] W_Instr,
  input  logic [4:0]  W_for_GRFWriteAddr,
  input  logic [31:0] W_ALUResult,
  input  logic [31:0] W_RD,
  input  logic [4:0]  D_rs_addr,
  input  logic [4:0]  D_rt_addr,
  output logic [31:0] D_rs_data,
  output logic [31:0] D_rt_data,
  output logic        W_GRFWE,
  output logic [31:0] W_GRFWriteData,
  output logic [31:0] instret
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_LB    = 6'b100000;
  localparam logic [5:0] OP_LH    = 6'b100001;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_LBU   = 6'b100100;
  localparam logic [5:0] OP_LHU   = 6'b100101;
  localparam logic [5:0] FN_JALR  = 6'b001001;

  logic [31:0] grf_r [0:31];
  logic [31:0] instret_r;
  logic [5:0]  op_s;
  logic [5:0]  fn_s;
  logic        is_write_s;
  logic        is_load_s;
  logic        is_link_s;
  logic [31:0] wdata_s;
  logic        unused_s;

  assign op_s     = W_Instr[31:26];
  assign fn_s     = W_Instr[5:0];
  // PC_RESET is informational; the middle instruction fields are not decoded here.
  assign unused_s = ^{W_Instr[25:6], PC_RESET};

  // Extract and extend the addressed byte/half of the loaded word.
  function automatic logic [31:0] load_ext(input logic [5:0] op,
                                           input logic [31:0] rd,
                                           input logic [1:0] a);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = rd[8*a +: 8];
    h = a[1] ? rd[31:16] : rd[15:0];
    case (op)
      OP_LB:   r = {{24{b[7]}}, b};
      OP_LBU:  r = {24'h000000, b};
      OP_LH:   r = {{16{h[15]}}, h};
      OP_LHU:  r = {16'h0000, h};
      default: r = rd;
    endcase
    return r;
  endfunction

  // Classify the W instruction: does it write, is it a load, is it a link.
  always_comb begin
    is_write_s = 1'b0;
    is_load_s  = 1'b0;
    is_link_s  = 1'b0;
    case (op_s)
      OP_RTYPE: begin
        is_link_s = (fn_s == FN_JALR);
        case (fn_s)
          6'b001000, 6'b001100, 6'b010001, 6'b010011,
          6'b011000, 6'b011001, 6'b011010, 6'b011011: is_write_s = 1'b0;
          default:                                    is_write_s = 1'b1;
        endcase
      end
      6'b001000, 6'b001001, 6'b001010, 6'b001011,
      6'b001100, 6'b001101, 6'b001110, 6'b001111: is_write_s = 1'b1;
      OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU: begin
        is_write_s = 1'b1;
        is_load_s  = 1'b1;
      end
      OP_JAL: begin
        is_write_s = 1'b1;
        is_link_s  = 1'b1;
      end
      default: is_write_s = 1'b0;
    endcase
  end

  // Select the writeback value: link address, extended load data or ALU result.
  always_comb begin
    if (is_link_s) begin
      wdata_s = W_PC + 32'd8;
    end else if (is_load_s) begin
      wdata_s = load_ext(op_s, W_RD, W_ALUResult[1:0]);
    end else begin
      wdata_s = W_ALUResult;
    end
  end

  assign W_GRFWE        = is_write_s && (W_for_GRFWriteAddr != 5'd0);
  assign W_GRFWriteData = wdata_s;

  // Register file storage; asynchronous clear, commit on the edge ending W.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 32; i++) begin
        grf_r[i] <= 32'h00000000;
      end
    end else if (W_GRFWE) begin
      grf_r[W_for_GRFWriteAddr] <= wdata_s;
    end
  end

  // Retired-instruction counter; bubbles do not count, wraps naturally.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      instret_r <= 32'h00000000;
    end else if (W_Instr != 32'h00000000) begin
      instret_r <= instret_r + 32'd1;
    end
  end

  assign instret = instret_r;

  // Read ports; $0 is hard-wired zero, optional same-cycle write bypass.
  always_comb begin
    if (D_rs_addr == 5'd0) begin
      D_rs_data = 32'h00000000;
`ifdef GRF_BYPASS_EN
    end else if (W_GRFWE && (D_rs_addr == W_for_GRFWriteAddr)) begin
      D_rs_data = wdata_s;
`endif
    end else begin
      D_rs_data = grf_r[D_rs_addr];
    end
    if (D_rt_addr == 5'd0) begin
      D_rt_data = 32'h00000000;
`ifdef GRF_BYPASS_EN
    end else if (W_GRFWE && (D_rt_addr == W_for_GRFWriteAddr)) begin
      D_rt_data = wdata_s;
`endif
    end else begin
      D_rt_data = grf_r[D_rt_addr];
    end
  end

endmodule

// File: tb/tb_grf_writeback.sv
// Directed self-checking bench for grf_writeback.
module tb_grf_writeback;

  logic        clk;
  logic        reset;
  logic [31:0] W_PC;
  logic [31:0] W_Instr;
  logic [4:0]  W_for_GRFWriteAddr;
  logic [31:0] W_ALUResult;
  logic [31:0] W_RD;
  logic [4:0]  D_rs_addr;
  logic [4:0]  D_rt_addr;
  logic [31:0] D_rs_data;
  logic [31:0] D_rt_data;
  logic        W_GRFWE;
  logic [31:0] W_GRFWriteData;
  logic [31:0] instret;

  int tests_run;
  int tests_failed;

  localparam logic [31:0] I_ORI  = 32'h34000000; // op 001101
  localparam logic [31:0] I_LB   = 32'h80000000; // op 100000
  localparam logic [31:0] I_LH   = 32'h84000000; // op 100001
  localparam logic [31:0] I_LW   = 32'h8C000000; // op 100011
  localparam logic [31:0] I_LBU  = 32'h90000000; // op 100100
  localparam logic [31:0] I_LHU  = 32'h94000000; // op 100101
  localparam logic [31:0] I_JAL  = 32'h0C000000; // op 000011
  localparam logic [31:0] I_JALR = 32'h00000009; // fn 001001
  localparam logic [31:0] I_MULT = 32'h00000018; // fn 011000
  localparam logic [31:0] I_JR   = 32'h00000008; // fn 001000
  localparam logic [31:0] I_ADDU = 32'h00000021; // fn 100001

  grf_writeback dut (
    .clk(clk), .reset(reset), .W_PC(W_PC), .W_Instr(W_Instr),
    .W_for_GRFWriteAddr(W_for_GRFWriteAddr), .W_ALUResult(W_ALUResult),
    .W_RD(W_RD), .D_rs_addr(D_rs_addr), .D_rt_addr(D_rt_addr),
    .D_rs_data(D_rs_data), .D_rt_data(D_rt_data), .W_GRFWE(W_GRFWE),
    .W_GRFWriteData(W_GRFWriteData), .instret(instret)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Set W-stage inputs at the falling edge, then let combinational logic settle.
  task automatic drive(input logic [31:0] pc, input logic [31:0] instr,
                       input logic [4:0] addr, input logic [31:0] alu,
                       input logic [31:0] rd);
    @(negedge clk);
    W_PC = pc; W_Instr = instr; W_for_GRFWriteAddr = addr;
    W_ALUResult = alu; W_RD = rd;
    #1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    W_PC = 32'h00003000; W_Instr = 32'h0; W_for_GRFWriteAddr = 5'd0;
    W_ALUResult = 32'h0; W_RD = 32'h0; D_rs_addr = 5'd1; D_rt_addr = 5'd31;
    #2;
    tests_run++;
    if (instret !== 32'h0) begin
      tests_failed++; $display("FAIL reset_instret: got %h expected %h", instret, 32'h0);
    end
    tests_run++;
    if (D_rs_data !== 32'h0 || D_rt_data !== 32'h0) begin
      tests_failed++; $display("FAIL reset_reads: got %h/%h expected 0", D_rs_data, D_rt_data);
    end
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_alu();
    D_rs_addr = 5'd8;
    drive(32'h00003000, I_ORI, 5'd8, 32'h0000ABCD, 32'h0);
    tests_run++;
    if (W_GRFWE !== 1'b1 || W_GRFWriteData !== 32'h0000ABCD) begin
      tests_failed++; $display("FAIL ori_we: got we=%b data=%h expected we=1 data=0000abcd", W_GRFWE, W_GRFWriteData);
    end
    step();
    W_Instr = 32'h0; #1;
    tests_run++;
    if (D_rs_data !== 32'h0000ABCD) begin
      tests_failed++; $display("FAIL ori_commit: got %h expected %h", D_rs_data, 32'h0000ABCD);
    end
    D_rs_addr = 5'd0;
    drive(32'h00003004, I_ORI, 5'd0, 32'h0000ABCD, 32'h0);
    tests_run++;
    if (W_GRFWE !== 1'b0) begin
      tests_failed++; $display("FAIL ori_zero_we: got %b expected 0", W_GRFWE);
    end
    step();
    tests_run++;
    if (D_rs_data !== 32'h0) begin
      tests_failed++; $display("FAIL zero_reg: got %h expected 0", D_rs_data);
    end
  endtask

  task automatic test_loads();
    logic [31:0] instrs [5];
    logic [1:0]  addrs  [5];
    logic [31:0] exp    [5];
    instrs[0] = I_LB;  addrs[0] = 2'd3; exp[0] = 32'hFFFFFF80;
    instrs[1] = I_LBU; addrs[1] = 2'd3; exp[1] = 32'h00000080;
    instrs[2] = I_LH;  addrs[2] = 2'd2; exp[2] = 32'hFFFF80F1;
    instrs[3] = I_LHU; addrs[3] = 2'd0; exp[3] = 32'h00007F02;
    instrs[4] = I_LW;  addrs[4] = 2'd0; exp[4] = 32'h80F17F02;
    for (int i = 0; i < 5; i++) begin
      D_rt_addr = 5'd10 + 5'(i);
      drive(32'h00003100, instrs[i], 5'd10 + 5'(i), {28'h0001000, 2'b00, addrs[i]}, 32'h80F17F02);
      tests_run++;
      if (W_GRFWE !== 1'b1 || W_GRFWriteData !== exp[i]) begin
        tests_failed++; $display("FAIL load_%0d: got we=%b data=%h expected we=1 data=%h", i, W_GRFWE, W_GRFWriteData, exp[i]);
      end
      step();
      W_Instr = 32'h0; #1;
      tests_run++;
      if (D_rt_data !== exp[i]) begin
        tests_failed++; $display("FAIL load_commit_%0d: got %h expected %h", i, D_rt_data, exp[i]);
      end
    end
  endtask

  task automatic test_link();
    D_rs_addr = 5'd31;
    drive(32'h00003010, I_JAL, 5'd31, 32'h12345678, 32'h0);
    step();
    W_Instr = 32'h0; #1;
    tests_run++;
    if (D_rs_data !== 32'h00003018) begin
      tests_failed++; $display("FAIL jal: got %h expected %h", D_rs_data, 32'h00003018);
    end
    D_rs_addr = 5'd4;
    drive(32'hFFFFFFFC, I_JALR, 5'd4, 32'h12345678, 32'h0);
    tests_run++;
    if (W_GRFWE !== 1'b1 || W_GRFWriteData !== 32'h00000004) begin
      tests_failed++; $display("FAIL jalr: got we=%b data=%h expected we=1 data=00000004", W_GRFWE, W_GRFWriteData);
    end
    step();
    drive(32'h00003020, I_MULT, 5'd4, 32'h0, 32'h0);
    tests_run++;
    if (W_GRFWE !== 1'b0) begin
      tests_failed++; $display("FAIL mult_we: got %b expected 0", W_GRFWE);
    end
    step();
    drive(32'h00003024, I_JR, 5'd4, 32'h0, 32'h0);
    tests_run++;
    if (W_GRFWE !== 1'b0) begin
      tests_failed++; $display("FAIL jr_we: got %b expected 0", W_GRFWE);
    end
    step();
    W_Instr = 32'h0; #1;
    tests_run++;
    if (D_rs_data !== 32'h00000004) begin
      tests_failed++; $display("FAIL jalr_kept: got %h expected %h", D_rs_data, 32'h00000004);
    end
  endtask

  task automatic test_bypass();
    D_rt_addr = 5'd9;
    drive(32'h00003030, I_ORI, 5'd9, 32'h00001111, 32'h0);
    step();
    drive(32'h00003034, I_ORI, 5'd9, 32'h0000DEAD, 32'h0);
`ifdef GRF_BYPASS_EN
    tests_run++;
    if (D_rt_data !== 32'h0000DEAD) begin
      tests_failed++; $display("FAIL bypass_same: got %h expected %h", D_rt_data, 32'h0000DEAD);
    end
`else
    tests_run++;
    if (D_rt_data !== 32'h00001111) begin
      tests_failed++; $display("FAIL bypass_same: got %h expected %h", D_rt_data, 32'h00001111);
    end
`endif
    step();
    W_Instr = 32'h0; #1;
    tests_run++;
    if (D_rt_data !== 32'h0000DEAD) begin
      tests_failed++; $display("FAIL bypass_next: got %h expected %h", D_rt_data, 32'h0000DEAD);
    end
  endtask

  task automatic test_reset_midrun();
    D_rs_addr = 5'd5; D_rt_addr = 5'd5;
    drive(32'h00003040, I_ORI, 5'd5, 32'h00001234, 32'h0);
    step();
    tests_run++;
    if (D_rs_data !== 32'h00001234 || D_rt_data !== 32'h00001234) begin
      tests_failed++; $display("FAIL pre_reset: got %h/%h expected 00001234", D_rs_data, D_rt_data);
    end
    reset = 1'b0;
    #1;
    tests_run++;
    if (D_rs_data !== 32'h0 || instret !== 32'h0) begin
      tests_failed++; $display("FAIL async_reset: got rs=%h instret=%h expected 0/0", D_rs_data, instret);
    end
    step();
    tests_run++;
    if (D_rs_data !== 32'h0 || instret !== 32'h0) begin
      tests_failed++; $display("FAIL held_reset: got rs=%h instret=%h expected 0/0", D_rs_data, instret);
    end
    @(negedge clk);
    W_Instr = 32'h0;
    reset = 1'b1;
  endtask

  task automatic test_counter();
    logic [31:0] seq [8];
    seq[0] = I_ADDU; seq[1] = 32'h0; seq[2] = I_ADDU; seq[3] = I_MULT;
    seq[4] = 32'h0;  seq[5] = I_ORI; seq[6] = 32'h0;  seq[7] = I_JR;
    for (int i = 0; i < 8; i++) begin
      drive(32'h00003050, seq[i], 5'd0, 32'h0, 32'h0);
      step();
    end
    W_Instr = 32'h0; #1;
    tests_run++;
    if (instret !== 32'd5) begin
      tests_failed++; $display("FAIL instret_count: got %0d expected 5", instret);
    end
    @(negedge clk);
    force dut.instret_r = 32'hFFFFFFFF;
    #1;
    release dut.instret_r;
    #1;
    tests_run++;
    if (instret !== 32'hFFFFFFFF) begin
      tests_failed++; $display("FAIL instret_preload: got %h expected ffffffff", instret);
    end
    W_Instr = I_ADDU;
    step();
    W_Instr = 32'h0; #1;
    tests_run++;
    if (instret !== 32'h0) begin
      tests_failed++; $display("FAIL instret_wrap: got %h expected 0", instret);
    end
  endtask

  initial begin
    tests_run = 0;
    tests_failed = 0;
    test_reset();
    test_alu();
    test_loads();
    test_link();
    test_bypass();
    test_reset_midrun();
    test_counter();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/grf_writeback.md
# grf_writeback

Writeback stage and general register file for the five-stage MIPS pipeline. It consumes the W-stage signals registered from M, decodes the instruction, selects and extends the writeback data, and commits it to the 32×32 GRF on the clock edge. It also serves the two D-stage read ports and exports the W-stage write value for forwarding. A retired-instruction counter is included for debug.

## Interface
Parameters:
- `PC_RESET`, default 32'h00003000: PC value the pipeline uses for an empty W slot. Informational only; not used in the datapath.

Ports:
- `clk` in 1: the single clock.
- `reset` in 1: asynchronous, active-low.
- `W_PC` in 32: PC of the W-stage instruction.
- `W_Instr` in 32: W-stage instruction word; 0 denotes a bubble.
- `W_for_GRFWriteAddr` in 5: destination register, already resolved upstream.
- `W_ALUResult` in 32: ALU result, or the effective address for loads.
- `W_RD` in 32: raw aligned word read from data memory.
- `D_rs_addr` in 5: D-stage read address, port A.
- `D_rt_addr` in 5: D-stage read address, port B.
- `D_rs_data` out 32: read data, port A (combinational).
- `D_rt_data` out 32: read data, port B (combinational).
- `W_GRFWE` out 1: effective write enable this cycle (combinational).
- `W_GRFWriteData` out 32: value being written this cycle (combinational).
- `instret` out 32: count of non-bubble instructions retired.

## Operation
Decode uses `op = W_Instr[31:26]` and `fn = W_Instr[5:0]`.

Write class:
- R-type (`op` = 0) writes, except `fn` ∈ {001000 jr, 001100 syscall, 010001 mthi, 010011 mtlo, 011000–011011 mult/multu/div/divu}.
- I-type ALU ops write: `op` 001000–001111.
- Loads write: 100000 lb, 100001 lh, 100011 lw, 100100 lbu, 100101 lhu.
- 000011 jal writes.
- All other opcodes do not write.

Enable:
- `W_GRFWE` = write class AND `W_for_GRFWriteAddr` ≠ 0.
- `$0` is never written and always reads 0.

Data select:
- jal, or jalr (`op` = 0, `fn` = 001001): `W_PC` + 8, modulo 2^32.
- Loads: `W_RD`, extended per the rules below.
- Otherwise: `W_ALUResult`.

Load extension, with `a = W_ALUResult[1:0]`:
- lw: the word as is.
- lb/lbu: byte `W_RD[8a+7:8a]`; sign-extended for lb, zero-extended for lbu.
- lh/lhu: half `W_RD[16·a[1]+15:16·a[1]]`; sign-extended for lh, zero-extended for lhu. `a[0]` is ignored, so misaligned halves are not trapped.

Register file:
- On posedge `clk` with `W_GRFWE` = 1, `grf[W_for_GRFWriteAddr] <= W_GRFWriteData`.

Read ports:
- Address 0 returns 0.
- Otherwise return `grf[addr]`, subject to the bypass rule in Configuration.

Counter:
- `instret` increments by 1 on every posedge where `W_Instr` ≠ 0, independent of `W_GRFWE`.
- Wraps from 32'hFFFFFFFF to 0.

## Timing
- Reset (`reset` = 0, asynchronous): all 31 writable registers and `instret` clear to 0 immediately, without waiting for a clock edge.
  - Consequently `D_rs_data` and `D_rt_data` read 0.
  - `W_GRFWE` and `W_GRFWriteData` remain combinational functions of the inputs.
- While `reset` = 0, no write and no count occurs, including when reset is asserted mid-stream. Release is synchronous to the next edge.
- Write latency: data is committed at the posedge ending the W cycle and is visible on the read ports from the following cycle.
- `W_GRFWE`/`W_GRFWriteData` are valid in the same cycle as their inputs, with no register stage.
- Simultaneous read and write of the same address: see Configuration.
- Both read ports addressing the same register return identical data.

## Configuration
- Macro: `GRF_BYPASS_EN`.
- Defined: a read port whose address equals `W_for_GRFWriteAddr` while `W_GRFWE` = 1 returns `W_GRFWriteData` in the same cycle. This write-before-read behaviour means the W→D forwarding path is not needed elsewhere.
- Undefined: read ports return stored contents only. The new value appears the cycle after the write, and the hazard unit must forward from W.

## Test plan
- **Reset.** Hold `reset` = 0 mid-run after writing `$5` = 32'h1234. Required: `D_rs_data` for `$5` reads 0 and `instret` reads 0 immediately, before any clock edge.
- **ALU writeback.** Apply ori $8 (`op` 001101), addr 8, `W_ALUResult` = 32'hABCD. Required: `W_GRFWE` = 1; the next cycle `$8` reads 32'hABCD. Then apply the same instruction with addr 0. Required: `W_GRFWE` = 0 and `$0` stays 0.
- **Loads.** Set `W_RD` = 32'h80F17F02.
  - lb, a = 3: writes 32'hFFFFFF80.
  - lbu, a = 3: writes 32'h00000080.
  - lh, a = 2: writes 32'hFFFF80F1.
  - lhu, a = 0: writes 32'h00007F02.
  - lw: writes 32'h80F17F02.
- **Link.** Apply jal with `W_PC` = 32'h00003010, addr 31. Required: `$31` = 32'h00003018. Also check jalr writes rd with PC+8. Check mult and jr give `W_GRFWE` = 0.
- **Bypass.** Write `$9` = 32'hDEAD while `D_rt_addr` = 9. With `GRF_BYPASS_EN` defined, `D_rt_data` = 32'hDEAD in the same cycle. Without it, the old value is returned that cycle and 32'hDEAD the next.
- **Counter.** Feed 5 instructions and 3 bubbles (`W_Instr` = 0). Required: `instret` = 5. Preload 32'hFFFFFFFF, then retire one instruction. Required: `instret` = 0.
